// File: rtl/baccarat_dealer.sv
// Baccarat round sequencer: deals player/banker card slots, applies the
// third-card rules to externally computed hand totals and flags the winner.
module baccarat_dealer #(
    parameter int unsigned CARD_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CARD_W-1:0] next_card,
    input  logic [CARD_W-1:0] pscore,
    input  logic [CARD_W-1:0] dscore,
    output logic [CARD_W-1:0] pcard1,
    output logic [CARD_W-1:0] pcard2,
    output logic [CARD_W-1:0] pcard3,
    output logic [CARD_W-1:0] dcard1,
    output logic [CARD_W-1:0] dcard2,
    output logic [CARD_W-1:0] dcard3,
    output logic              busy,
    output logic              done,
    output logic              player_win,
    output logic              dealer_win
);

    localparam int unsigned SUM_W = CARD_W + 1;

    typedef enum logic [3:0] {
        IDLE, PC1, DC1, PC2, DC2, NAT_CHK, PC3, BNK_CHK, DC3, RESULT
    } state_t;

    state_t              state_q, state_d;
    logic                card_ok;
    logic                clear_c;
    logic                win_ld;
    logic [5:0]          ld;
    logic                pw_d, dw_d;
    logic                bank_draw;
    logic [CARD_W-1:0]   v3;
    logic [CARD_W-1:0]   dnew;
    logic [SUM_W-1:0]    dsum;

    // Baccarat point value of a card: 10..13 and empty slots count zero
    function automatic logic [CARD_W-1:0] face(input logic [CARD_W-1:0] c);
        return (c <= CARD_W'(9)) ? c : '0;
    endfunction

    assign card_ok = (next_card != '0) && (next_card <= CARD_W'(13));
    assign v3      = face(pcard3);

    // Banker total including the card being dealt into dcard3 this edge,
    // since scorehand only sees it one cycle later.
    assign dsum = SUM_W'(dscore) + SUM_W'(face(next_card));
    assign dnew = (dsum >= SUM_W'(10)) ? CARD_W'(dsum - SUM_W'(10)) : CARD_W'(dsum);

    // Banker third-card decision after the player drew
    always_comb begin
        bank_draw = 1'b0;
        case (dscore)
            CARD_W'(0), CARD_W'(1), CARD_W'(2): bank_draw = 1'b1;
            CARD_W'(3): bank_draw = (v3 != CARD_W'(8));
            CARD_W'(4): bank_draw = (v3 >= CARD_W'(2)) && (v3 <= CARD_W'(7));
            CARD_W'(5): bank_draw = (v3 >= CARD_W'(4)) && (v3 <= CARD_W'(7));
            CARD_W'(6): bank_draw = (v3 >= CARD_W'(6)) && (v3 <= CARD_W'(7));
            default:    bank_draw = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        clear_c = 1'b0;
        win_ld  = 1'b0;
        ld      = '0;
        pw_d    = (pscore >= dscore);
        dw_d    = (dscore >= pscore);
        case (state_q)
            IDLE, RESULT: begin
                if (start) begin
                    clear_c = 1'b1;
                    state_d = PC1;
                end
            end
            PC1: if (card_ok) begin ld[0] = 1'b1; state_d = DC1;     end
            DC1: if (card_ok) begin ld[1] = 1'b1; state_d = PC2;     end
            PC2: if (card_ok) begin ld[2] = 1'b1; state_d = DC2;     end
            DC2: if (card_ok) begin ld[3] = 1'b1; state_d = NAT_CHK; end
            NAT_CHK: begin
                if ((pscore >= CARD_W'(8)) || (dscore >= CARD_W'(8))) begin
                    state_d = RESULT;
                    win_ld  = 1'b1;
                end else if (pscore <= CARD_W'(5)) begin
                    state_d = PC3;
                end else if (dscore <= CARD_W'(5)) begin
                    state_d = DC3;
                end else begin
                    state_d = RESULT;
                    win_ld  = 1'b1;
                end
            end
            PC3: if (card_ok) begin ld[4] = 1'b1; state_d = BNK_CHK; end
            BNK_CHK: begin
                if (bank_draw) begin
                    state_d = DC3;
                end else begin
                    state_d = RESULT;
                    win_ld  = 1'b1;
                end
            end
            DC3: begin
                if (card_ok) begin
                    ld[5]   = 1'b1;
                    state_d = RESULT;
                    win_ld  = 1'b1;
                    pw_d    = (pscore >= dnew);
                    dw_d    = (dnew >= pscore);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Card slot registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear_c) begin
            pcard1 <= '0;
            pcard2 <= '0;
            pcard3 <= '0;
            dcard1 <= '0;
            dcard2 <= '0;
            dcard3 <= '0;
        end else begin
            if (ld[0]) pcard1 <= next_card;
            if (ld[1]) dcard1 <= next_card;
            if (ld[2]) pcard2 <= next_card;
            if (ld[3]) dcard2 <= next_card;
            if (ld[4]) pcard3 <= next_card;
            if (ld[5]) dcard3 <= next_card;
        end
    end

    // Status and result flags, registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            player_win <= 1'b0;
            dealer_win <= 1'b0;
        end else begin
            busy <= !(state_d inside {IDLE, RESULT});
            done <= (state_d == RESULT);
            if (clear_c) begin
                player_win <= 1'b0;
                dealer_win <= 1'b0;
            end else if (win_ld) begin
                player_win <= pw_d;
                dealer_win <= dw_d;
            end
        end
    end

endmodule

// File: tb/tb_baccarat_dealer.sv
// Randomized bench for baccarat_dealer; hand totals come from a behavioural
// scorehand and each round is predicted from the game rules.
module tb_baccarat_dealer;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [3:0] next_card, pscore, dscore;
    logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
    logic       busy, done, player_win, dealer_win;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    baccarat_dealer #(.CARD_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .next_card(next_card),
        .pscore(pscore), .dscore(dscore),
        .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
        .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
        .busy(busy), .done(done), .player_win(player_win), .dealer_win(dealer_win)
    );

    function automatic int fv(input logic [3:0] c);
        return (c >= 4'd1 && c <= 4'd9) ? int'(c) : 0;
    endfunction

    function automatic logic [3:0] hand(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        return 4'((fv(a) + fv(b) + fv(c)) % 10);
    endfunction

    assign pscore = hand(pcard1, pcard2, pcard3);
    assign dscore = hand(dcard1, dcard2, dcard3);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // slot index: 0..2 = pcard1..3, 3..5 = dcard1..3
    function automatic logic [3:0] slot(input int i);
        case (i)
            0: return pcard1;
            1: return pcard2;
            2: return pcard3;
            3: return dcard1;
            4: return dcard2;
            default: return dcard3;
        endcase
    endfunction

    function automatic logic [3:0] bad_card();
        case ($urandom_range(0, 2))
            0: return 4'd0;
            1: return 4'd14;
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic rnd_start();
        return ($urandom_range(0, 3) == 0);
    endfunction

    task automatic run_round(input logic [3:0] cv [6], input int stall0, input bit rstall, input bit glitch);
        int seq[$];
        logic [3:0] e [6];
        int ps, ds, ci, v, n, s;
        bit draw, pw, dw;
        foreach (e[i]) e[i] = 4'd0;
        // Predict the round: dealt slots in order, -1 marks a score-check cycle
        e[0] = cv[0]; e[3] = cv[1]; e[1] = cv[2]; e[4] = cv[3]; ci = 4;
        seq = '{0, 3, 1, 4, -1};
        ps = (fv(e[0]) + fv(e[1])) % 10;
        ds = (fv(e[3]) + fv(e[4])) % 10;
        if (!(ps >= 8 || ds >= 8)) begin
            if (ps <= 5) begin
                e[2] = cv[ci]; ci++;
                seq.push_back(2);
                seq.push_back(-1);
                v = fv(e[2]);
                draw = (ds <= 2) || (ds == 3 && v != 8) || (ds == 4 && v >= 2 && v <= 7) ||
                       (ds == 5 && v >= 4 && v <= 7) || (ds == 6 && v >= 6 && v <= 7);
            end else begin
                draw = (ds <= 5);
            end
            if (draw) begin
                e[5] = cv[ci];
                seq.push_back(5);
            end
        end
        ps = (fv(e[0]) + fv(e[1]) + fv(e[2])) % 10;
        ds = (fv(e[3]) + fv(e[4]) + fv(e[5])) % 10;
        pw = (ps >= ds);
        dw = (ds >= ps);

        @(negedge clk); start = 1'b1; next_card = 4'($urandom_range(0, 15));
        @(posedge clk); #1;
        chk("start_clear", {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}, 0);
        chk("start_status", {busy, done, player_win, dealer_win}, 4'b1000);

        foreach (seq[k]) begin
            s = seq[k];
            if (s >= 0) begin
                n = (k == 0) ? stall0 : (rstall ? int'($urandom_range(0, 2)) : 0);
                for (int j = 0; j < n; j++) begin
                    @(negedge clk); start = rnd_start(); next_card = bad_card();
                    @(posedge clk); #1;
                    chk("stall_hold", slot(s), 0);
                    chk("stall_busy", busy, 1);
                end
                @(negedge clk);
                start = (glitch && s == 3) ? 1'b1 : rnd_start();
                next_card = e[s];
                @(posedge clk); #1;
                chk("deal_load", slot(s), e[s]);
            end else begin
                @(negedge clk); start = rnd_start(); next_card = 4'($urandom_range(0, 15));
                @(posedge clk); #1;
            end
            if (k < seq.size() - 1) chk("busy_mid", {busy, done}, 2'b10);
        end

        chk("final_status", {busy, done}, 2'b01);
        chk("final_cards", {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3},
            {e[0], e[1], e[2], e[3], e[4], e[5]});
        chk("final_flags", {player_win, dealer_win}, {pw, dw});
        @(negedge clk); start = 1'b0; next_card = 4'($urandom_range(0, 15));
        @(posedge clk); #1;
        chk("result_hold", {busy, done, player_win, dealer_win}, {2'b01, pw, dw});
    endtask

    logic [3:0] cv [6];

    initial begin
        reset = 1'b1; start = 1'b0; next_card = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cards", {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}, 0);
        chk("reset_status", {busy, done, player_win, dealer_win}, 0);
        @(negedge clk); reset = 1'b0;

        // natural: player 9
        cv = '{4'd4, 4'd2, 4'd5, 4'd3, 4'd1, 4'd1};
        run_round(cv, 0, 1'b0, 1'b0);
        // banker 3 stands on player third card 8: tie at 3
        cv = '{4'd2, 4'd10, 4'd3, 4'd3, 4'd8, 4'd1};
        run_round(cv, 0, 1'b0, 1'b0);
        // banker 6 draws on 7: player 9 vs banker 8
        cv = '{4'd1, 4'd3, 4'd1, 4'd3, 4'd7, 4'd2};
        run_round(cv, 0, 1'b0, 1'b0);
        // three stall cycles in PC1, start pulsed during DC1
        cv = '{4'd5, 4'd6, 4'd12, 4'd13, 4'd9, 4'd4};
        run_round(cv, 3, 1'b0, 1'b1);

        // reset in the middle of a round
        @(negedge clk); start = 1'b1; next_card = 4'd0;
        @(posedge clk);
        @(negedge clk); start = 1'b0; next_card = 4'd7;
        @(posedge clk);
        @(negedge clk); next_card = 4'd9;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrun_reset_cards", {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}, 0);
        chk("midrun_reset_status", {busy, done, player_win, dealer_win}, 0);
        @(negedge clk); reset = 1'b0;

        for (int r = 0; r < 150; r++) begin
            foreach (cv[i]) cv[i] = 4'($urandom_range(1, 13));
            run_round(cv, int'($urandom_range(0, 2)), 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
